// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table, polarity
// and parameter limits.
package seg7_pkg;

  localparam int MAX_DIGITS    = 8;
  localparam int MAX_DUTY_BITS = 8;
  localparam int MIN_DIVIDER   = 4;

  // Segment outputs are active low; SEG_OFF is the all-dark pattern.
  localparam bit         SEG_ACTIVE_LOW = 1'b1;
  localparam logic [6:0] SEG_OFF        = 7'h7F;

  // Active-high {g,f,e,d,c,b,a} glyphs for 0-F, with b and d in lowercase.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment decoder with the board's
// segment polarity applied.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = SEG_ACTIVE_LOW ? ~HEX_SEG[nibble] : HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver: one digit per DIVIDER-cycle slot,
// PWM brightness within the slot, all outputs registered.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int DIVIDER   = 10000,
  parameter int DUTY_BITS = 4
) (
  input  logic                   CLOCK,
  input  logic                   Reset,
  input  logic                   Enable,
  input  logic [4*DIGITS-1:0]    Digits,
  input  logic [DIGITS-1:0]      DecimalPoints,
  input  logic [DIGITS-1:0]      Blank,
  input  logic [DUTY_BITS-1:0]   Brightness,
  output logic [DIGITS-1:0]      Transistors,
  output logic [6:0]             Segments,
  output logic                   DP,
  output logic                   FrameStart
);

  localparam int CW = $clog2(DIVIDER);
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int LW = DUTY_BITS + CW + 1;

  if (DIGITS < 1 || DIGITS > MAX_DIGITS || DUTY_BITS < 1 ||
      DUTY_BITS > MAX_DUTY_BITS || DIVIDER < MIN_DIVIDER) begin : g_param_check
    $error("seg7_scan_driver: parameter out of range");
  end

  logic [CW-1:0]        count;
  logic [SW-1:0]        slot;
  logic [3:0]           nib_held;
  logic                 dp_held;
  logic                 blank_held;
  logic [DUTY_BITS-1:0] bright_held;

  logic                 slot_start;
  logic [3:0]           nib_cur;
  logic                 dp_cur;
  logic                 blank_cur;
  logic [DUTY_BITS-1:0] bright_cur;
  logic [LW-1:0]        on_limit;
  logic                 anode_on;
  logic [DIGITS-1:0]    tr_next;
  logic [6:0]           seg_glyph;

  assign slot_start = (count == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, matching real flip-flops.
  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) begin
      count <= '0;
      slot  <= '0;
    end else if (!Enable) begin
      count <= '0;
      slot  <= '0;
    end else if (count == CW'(DIVIDER - 1)) begin
      count <= '0;
      slot  <= (slot == SW'(DIGITS - 1)) ? '0 : slot + 1'b1;
    end else begin
      count <= count + 1'b1;
    end
  end

  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) begin
      nib_held    <= '0;
      dp_held     <= 1'b0;
      blank_held  <= 1'b0;
      bright_held <= '0;
    end else if (Enable && slot_start) begin
      nib_held    <= nib_cur;
      dp_held     <= dp_cur;
      blank_held  <= blank_cur;
      bright_held <= bright_cur;
    end
  end

  // On the first cycle of a slot the live inputs feed the output stage
  // directly; for the rest of the slot only the held copies are used.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    nib_cur    = nib_held;
    dp_cur     = dp_held;
    blank_cur  = blank_held;
    bright_cur = bright_held;
    if (slot_start) begin
      nib_cur    = Digits[4*int'(slot) +: 4];
      dp_cur     = DecimalPoints[slot];
      blank_cur  = Blank[slot];
      bright_cur = Brightness;
    end
  end

  always_comb begin
    on_limit = ((LW'(bright_cur) + LW'(1)) * LW'(DIVIDER)) >> DUTY_BITS;
    anode_on = (LW'(count) < on_limit) && !blank_cur;
    tr_next  = '1;
    if (anode_on) tr_next[slot] = 1'b0;
  end

  seg7_hex_decode u_decode (
    .nibble   (nib_cur),
    .segments (seg_glyph)
  );

  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset || !Enable) begin
      Transistors <= '1;
      Segments    <= SEG_OFF;
      DP          <= 1'b1;
      FrameStart  <= 1'b0;
    end else begin
      Transistors <= tr_next;
      Segments    <= anode_on ? seg_glyph : SEG_OFF;
      DP          <= ~(anode_on & dp_cur);
      FrameStart  <= slot_start && (slot == '0);
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with DIGITS=4, DIVIDER=8,
// DUTY_BITS=2: per-slot vector table plus hand-written timing sequences.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dps;
  logic [3:0]  blank;
  logic [1:0]  bright;
  logic [3:0]  tr;
  logic [6:0]  seg;
  logic        dp;
  logic        fs;

  int n_checks = 0;
  int n_pass   = 0;

  seg7_scan_driver #(.DIGITS(4), .DIVIDER(8), .DUTY_BITS(2)) dut (
    .CLOCK         (clk),
    .Reset         (rst),
    .Enable        (en),
    .Digits        (digits),
    .DecimalPoints (dps),
    .Blank         (blank),
    .Brightness    (bright),
    .Transistors   (tr),
    .Segments      (seg),
    .DP            (dp),
    .FrameStart    (fs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dps;
    logic [3:0]  blank;
    logic [1:0]  bright;
    int          slot;
    int          on_cycles;
    logic [3:0]  tr_on;
    logic [6:0]  seg_on;
    logic        dp_on;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic add_vec(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                         input logic [1:0] br, input int s, input int on,
                         input logic [3:0] t, input logic [6:0] sg, input logic dpo);
    vec_t v;
    v.digits = d; v.dps = p; v.blank = b; v.bright = br; v.slot = s;
    v.on_cycles = on; v.tr_on = t; v.seg_on = sg; v.dp_on = dpo;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench on a negedge with reset just released; the next step()
  // samples the outputs for count 0 of slot 0.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; digits = 16'h1234; dps = '0; blank = '0; bright = 2'd3;
    #1;
    check("reset_tr",  tr,  4'hF);
    check("reset_seg", seg, 7'h7F);
    check("reset_dp",  dp,  1'b1);
    check("reset_fs",  fs,  1'b0);

    add_vec(16'h1234, 4'h0, 4'h0, 2'd3, 0, 8, 4'hE, 7'h19, 1'b1);
    add_vec(16'h1234, 4'h0, 4'h0, 2'd3, 1, 8, 4'hD, 7'h30, 1'b1);
    add_vec(16'h1234, 4'h0, 4'h0, 2'd3, 2, 8, 4'hB, 7'h24, 1'b1);
    add_vec(16'h1234, 4'h0, 4'h0, 2'd3, 3, 8, 4'h7, 7'h79, 1'b1);
    add_vec(16'h1234, 4'h0, 4'h0, 2'd0, 1, 2, 4'hD, 7'h30, 1'b1);
    add_vec(16'h1234, 4'h0, 4'h0, 2'd1, 0, 4, 4'hE, 7'h19, 1'b1);
    add_vec(16'h1234, 4'h0, 4'h0, 2'd2, 3, 6, 4'h7, 7'h79, 1'b1);
    add_vec(16'h1234, 4'h0, 4'h4, 2'd3, 2, 0, 4'hB, 7'h24, 1'b1);
    add_vec(16'h1234, 4'h0, 4'h4, 2'd3, 3, 8, 4'h7, 7'h79, 1'b1);
    add_vec(16'h1234, 4'h2, 4'h0, 2'd3, 1, 8, 4'hD, 7'h30, 1'b0);
    add_vec(16'h1234, 4'h4, 4'h4, 2'd3, 2, 0, 4'hB, 7'h24, 1'b0);
    add_vec(16'hF0E8, 4'h1, 4'h0, 2'd3, 0, 8, 4'hE, 7'h00, 1'b0);
    add_vec(16'hF0E8, 4'h0, 4'h0, 2'd3, 1, 8, 4'hD, 7'h06, 1'b1);
    add_vec(16'hF0E8, 4'h0, 4'h0, 2'd3, 2, 8, 4'hB, 7'h40, 1'b1);
    add_vec(16'hF0E8, 4'h0, 4'h0, 2'd3, 3, 8, 4'h7, 7'h0E, 1'b1);
    add_vec(16'hABCD, 4'h0, 4'h0, 2'd3, 0, 8, 4'hE, 7'h21, 1'b1);
    add_vec(16'hABCD, 4'h0, 4'h0, 2'd3, 1, 8, 4'hD, 7'h46, 1'b1);
    add_vec(16'hABCD, 4'h0, 4'h0, 2'd3, 2, 8, 4'hB, 7'h03, 1'b1);
    add_vec(16'hABCD, 4'h0, 4'h0, 2'd3, 3, 8, 4'h7, 7'h08, 1'b1);
    add_vec(16'h9765, 4'h0, 4'h0, 2'd3, 0, 8, 4'hE, 7'h12, 1'b1);
    add_vec(16'h9765, 4'h0, 4'h0, 2'd3, 1, 8, 4'hD, 7'h02, 1'b1);
    add_vec(16'h9765, 4'h0, 4'h0, 2'd3, 2, 8, 4'hB, 7'h78, 1'b1);
    add_vec(16'h9765, 4'h0, 4'h0, 2'd3, 3, 8, 4'h7, 7'h10, 1'b1);

    foreach (vecs[v]) begin
      digits = vecs[v].digits; dps = vecs[v].dps;
      blank  = vecs[v].blank;  bright = vecs[v].bright;
      do_reset();
      for (int k = 0; k < vecs[v].slot * 8; k++) step();
      for (int c = 0; c < 8; c++) begin
        step();
        check($sformatf("vec%0d_c%0d_tr", v, c), tr,
              (c < vecs[v].on_cycles) ? vecs[v].tr_on : 4'hF);
        check($sformatf("vec%0d_c%0d_seg", v, c), seg,
              (c < vecs[v].on_cycles) ? vecs[v].seg_on : 7'h7F);
        check($sformatf("vec%0d_c%0d_dp", v, c), dp,
              (c < vecs[v].on_cycles) ? vecs[v].dp_on : 1'b1);
        check($sformatf("vec%0d_c%0d_fs", v, c), fs, (vecs[v].slot == 0 && c == 0));
      end
    end

    // FrameStart period: one pulse every 32 cycles.
    digits = 16'h1234; dps = '0; blank = '0; bright = 2'd3;
    do_reset();
    for (int i = 0; i < 70; i++) begin
      step();
      check($sformatf("frame_fs_%0d", i), fs, (i % 32) == 0);
    end

    // Enable dropped in slot 2, then restored.
    do_reset();
    for (int i = 0; i < 18; i++) step();
    check("en_pre_tr", tr, 4'hB);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("en_off_tr_%0d", i), tr, 4'hF);
      check($sformatf("en_off_seg_%0d", i), seg, 7'h7F);
      check($sformatf("en_off_dp_%0d", i), dp, 1'b1);
      check($sformatf("en_off_fs_%0d", i), fs, 1'b0);
    end
    en = 1'b1;
    step();
    check("en_on_tr",  tr,  4'hE);
    check("en_on_fs",  fs,  1'b1);
    check("en_on_seg", seg, 7'h19);
    step();
    check("en_on2_fs", fs, 1'b0);
    check("en_on2_tr", tr, 4'hE);

    // Asynchronous reset between edges, mid slot 1.
    do_reset();
    for (int i = 0; i < 12; i++) step();
    check("arst_pre_tr", tr, 4'hD);
    #2 rst = 1'b1;
    #1;
    check("arst_tr",  tr,  4'hF);
    check("arst_seg", seg, 7'h7F);
    check("arst_dp",  dp,  1'b1);
    check("arst_fs",  fs,  1'b0);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("arst_slot0_tr_%0d", i), tr, 4'hE);
    end
    step();
    check("arst_slot1_tr", tr, 4'hD);

    // Digits and Brightness changed mid slot 1: slot 1 keeps its held values.
    digits = 16'h1234; bright = 2'd3;
    do_reset();
    for (int i = 0; i < 12; i++) step();
    digits = 16'hABCD; bright = 2'd0;
    for (int i = 12; i < 16; i++) begin
      step();
      check($sformatf("mid_s1_tr_%0d", i), tr, 4'hD);
      check($sformatf("mid_s1_seg_%0d", i), seg, 7'h30);
    end
    for (int i = 16; i < 18; i++) begin
      step();
      check($sformatf("mid_s2_tr_%0d", i), tr, 4'hB);
      check($sformatf("mid_s2_seg_%0d", i), seg, 7'h03);
    end
    step();
    check("mid_s2_off_tr", tr, 4'hF);
    check("mid_s2_off_seg", seg, 7'h7F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
